// File: rtl/interrupt_control_if.sv
// Sequencer-side bundle of the interrupt controller.
// The sequencer is the master; the controller is the slave.
interface interrupt_control_if;
  logic       i_p_i;
  logic       i_sample;
  logic       i_brk;
  logic       i_vec_lo;
  logic       i_vec_hi;
  logic [1:0] o_vec_sel;
  logic       o_force_brk;
  logic       o_b_push;
  logic       o_set_i;

  modport master (
    output i_p_i,
    output i_sample,
    output i_brk,
    output i_vec_lo,
    output i_vec_hi,
    input  o_vec_sel,
    input  o_force_brk,
    input  o_b_push,
    input  o_set_i
  );

  modport slave (
    input  i_p_i,
    input  i_sample,
    input  i_brk,
    input  i_vec_lo,
    input  i_vec_hi,
    output o_vec_sel,
    output o_force_brk,
    output o_b_push,
    output o_set_i
  );
endinterface

// File: rtl/interrupt_control.sv
// 6502-style interrupt controller: RESET/NMI/IRQ/BRK arbitration.
// All state moves on the falling CPU clock edge, like the P register.
module interrupt_control #(
  parameter int SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_nmi_n,
  input  logic               i_irq_n,
  output logic               o_nmi_pending,
  interrupt_control_if.slave bus
);

  typedef enum logic [1:0] {
    S_RESET,
    S_IDLE,
    S_TAKEN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SYNC_STAGES-1:0] nmi_sync;
  logic [SYNC_STAGES-1:0] irq_sync;

  logic nmi_s;
  logic irq_s;
  logic nmi_prev;
  logic nmi_fall;
  logic irq_req;

  logic nmi_latch_q;
  logic nmi_latch_d;
  logic nmi_clr;

  logic sel_nmi_q;
  logic sel_nmi_d;
  logic force_q;
  logic force_d;
  logic bpush_q;
  logic bpush_d;
  logic frozen_q;
  logic frozen_d;
  logic set_i_q;
  logic set_i_d;

  assign nmi_s    = nmi_sync[SYNC_STAGES-1];
  assign irq_s    = irq_sync[SYNC_STAGES-1];
  assign nmi_fall = nmi_prev & ~nmi_s;
  assign irq_req  = ~irq_s & ~bus.i_p_i;

  // Pin synchronisers; nmi_prev turns the level into an edge.
  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      nmi_sync <= '1;
      irq_sync <= '1;
      nmi_prev <= 1'b1;
    end else begin
      nmi_sync[0] <= i_nmi_n;
      irq_sync[0] <= i_irq_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        nmi_sync[i] <= nmi_sync[i-1];
        irq_sync[i] <= irq_sync[i-1];
      end
      nmi_prev <= nmi_s;
    end
  end

  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_RESET;
      nmi_latch_q <= 1'b0;
      sel_nmi_q   <= 1'b0;
      force_q     <= 1'b0;
      bpush_q     <= 1'b0;
      frozen_q    <= 1'b0;
      set_i_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      nmi_latch_q <= nmi_latch_d;
      sel_nmi_q   <= sel_nmi_d;
      force_q     <= force_d;
      bpush_q     <= bpush_d;
      frozen_q    <= frozen_d;
      set_i_q     <= set_i_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_nmi_d = sel_nmi_q;
    force_d   = force_q;
    bpush_d   = bpush_q;
    frozen_d  = frozen_q;
    set_i_d   = 1'b0;
    nmi_clr   = 1'b0;
    unique case (state_q)
      S_RESET: begin
        if (bus.i_vec_hi) begin
          state_d = S_IDLE;
          set_i_d = 1'b1;
        end
      end
      S_IDLE: begin
        sel_nmi_d = 1'b0;
        force_d   = 1'b0;
        bpush_d   = 1'b0;
        frozen_d  = 1'b0;
        if (bus.i_sample) begin
          if (nmi_latch_q) begin
            state_d   = S_TAKEN;
            sel_nmi_d = 1'b1;
            force_d   = 1'b1;
          end else if (irq_req) begin
            state_d = S_TAKEN;
            force_d = 1'b1;
          end else if (bus.i_brk) begin
            state_d = S_TAKEN;
            bpush_d = 1'b1;
          end
        end
      end
      S_TAKEN: begin
        if (bus.i_vec_hi) begin
          state_d   = S_IDLE;
          set_i_d   = 1'b1;
          nmi_clr   = sel_nmi_q;
          sel_nmi_d = 1'b0;
          force_d   = 1'b0;
          bpush_d   = 1'b0;
          frozen_d  = 1'b0;
        end else begin
          // Late NMI steals an IRQ/BRK until the low byte is fetched.
          if (!frozen_q && !bus.i_vec_lo && nmi_latch_q)
            sel_nmi_d = 1'b1;
          if (bus.i_vec_lo)
            frozen_d = 1'b1;
        end
      end
      default: state_d = S_RESET;
    endcase
    nmi_latch_d = nmi_fall | (nmi_latch_q & ~nmi_clr);
  end

  always_comb begin
    bus.o_vec_sel   = 2'd0;
    bus.o_force_brk = 1'b0;
    bus.o_b_push    = 1'b0;
    unique case (state_q)
      S_RESET: begin
        bus.o_vec_sel   = 2'd3;
        bus.o_force_brk = 1'b1;
      end
      S_TAKEN: begin
        bus.o_vec_sel   = sel_nmi_q ? 2'd2 : 2'd1;
        bus.o_force_brk = force_q;
        bus.o_b_push    = bpush_q;
      end
      default: ;
    endcase
  end

  assign bus.o_set_i    = set_i_q;
  assign o_nmi_pending  = nmi_latch_q;

endmodule

// File: tb/tb_interrupt_control.sv
// Directed + random bench for interrupt_control against a
// sequence-level reference model.
module tb_interrupt_control;

  localparam int N = 2;

  localparam int K_NONE = 0;
  localparam int K_IRQ  = 1;
  localparam int K_BRK  = 2;
  localparam int K_NMI  = 3;
  localparam int K_RST  = 4;

  logic i_clk = 1'b0;
  logic i_reset_n = 1'b1;
  logic i_nmi_n = 1'b1;
  logic i_irq_n = 1'b1;
  logic o_nmi_pending;

  interrupt_control_if bus ();

  interrupt_control #(.SYNC_STAGES(N)) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_nmi_n       (i_nmi_n),
    .i_irq_n       (i_irq_n),
    .o_nmi_pending (o_nmi_pending),
    .bus           (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: which service is in progress, plus flags.
  int m_kind;
  bit m_hijack;
  bit m_frozen;
  bit m_pend;
  bit m_seti;
  bit m_ns;
  bit m_ns_old;
  bit m_is;
  bit q_nmi[$];
  bit q_irq[$];

  function automatic void m_reset();
    m_kind   = K_RST;
    m_hijack = 0;
    m_frozen = 0;
    m_pend   = 0;
    m_seti   = 0;
    m_ns     = 1;
    m_ns_old = 1;
    m_is     = 1;
    q_nmi    = {};
    q_irq    = {};
    for (int i = 0; i < N; i++) begin
      q_nmi.push_back(1'b1);
      q_irq.push_back(1'b1);
    end
  endfunction

  function automatic logic [1:0] e_sel();
    case (m_kind)
      K_RST:   return 2'd3;
      K_NONE:  return 2'd0;
      K_NMI:   return 2'd2;
      default: return m_hijack ? 2'd2 : 2'd1;
    endcase
  endfunction

  function automatic logic e_force();
    return (m_kind == K_RST || m_kind == K_IRQ || m_kind == K_NMI);
  endfunction

  function automatic logic e_bpush();
    return (m_kind == K_BRK);
  endfunction

  function automatic void m_step();
    bit fall;
    bit clr;
    bit nseti;
    fall  = m_ns_old && !m_ns;
    clr   = 0;
    nseti = 0;
    if (m_kind == K_RST) begin
      if (bus.i_vec_hi) begin
        m_kind = K_NONE;
        nseti  = 1;
      end
    end else if (m_kind == K_NONE) begin
      m_hijack = 0;
      m_frozen = 0;
      if (bus.i_sample) begin
        if (m_pend)
          m_kind = K_NMI;
        else if (!m_is && !bus.i_p_i)
          m_kind = K_IRQ;
        else if (bus.i_brk)
          m_kind = K_BRK;
      end
    end else begin
      if (bus.i_vec_hi) begin
        clr      = (e_sel() == 2'd2);
        m_kind   = K_NONE;
        nseti    = 1;
        m_hijack = 0;
        m_frozen = 0;
      end else begin
        if (!m_frozen && !bus.i_vec_lo && m_pend && e_sel() == 2'd1)
          m_hijack = 1;
        if (bus.i_vec_lo)
          m_frozen = 1;
      end
    end
    m_seti = nseti;
    m_pend = fall | (m_pend & !clr);
    q_nmi.push_back(i_nmi_n);
    void'(q_nmi.pop_front());
    q_irq.push_back(i_irq_n);
    void'(q_irq.pop_front());
    m_ns_old = m_ns;
    m_ns     = q_nmi[0];
    m_is     = q_irq[0];
  endfunction

  task automatic check(input string tag,
                       input logic [1:0] obs,
                       input logic [1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".vec_sel"}, bus.o_vec_sel, e_sel());
    check({tag, ".force_brk"}, {1'b0, bus.o_force_brk}, {1'b0, e_force()});
    check({tag, ".b_push"}, {1'b0, bus.o_b_push}, {1'b0, e_bpush()});
    check({tag, ".set_i"}, {1'b0, bus.o_set_i}, {1'b0, m_seti});
    check({tag, ".nmi_pend"}, {1'b0, o_nmi_pending}, {1'b0, m_pend});
  endtask

  task automatic tick(input string tag, input int n = 1);
    repeat (n) begin
      @(negedge i_clk);
      if (i_reset_n)
        m_step();
      #1;
      check_all(tag);
    end
  endtask

  task automatic pulse_sample(input string tag);
    bus.i_sample = 1'b1;
    tick(tag);
    bus.i_sample = 1'b0;
  endtask

  task automatic pulse_lo(input string tag);
    bus.i_vec_lo = 1'b1;
    tick(tag);
    bus.i_vec_lo = 1'b0;
  endtask

  task automatic pulse_hi(input string tag);
    bus.i_vec_hi = 1'b1;
    tick(tag);
    bus.i_vec_hi = 1'b0;
  endtask

  initial begin
    bus.i_p_i    = 1'b1;
    bus.i_sample = 1'b0;
    bus.i_brk    = 1'b0;
    bus.i_vec_lo = 1'b0;
    bus.i_vec_hi = 1'b0;
    m_reset();
    #1 i_reset_n = 1'b0;
    tick("reset", 2);
    #2 i_reset_n = 1'b1;

    // Reset sequence ends only on vec_hi.
    tick("rst_hold", 3);
    pulse_hi("rst_hi");
    tick("rst_done", 2);

    // Masked IRQ ignored, unmasked IRQ taken.
    i_irq_n   = 1'b0;
    bus.i_p_i = 1'b1;
    tick("irq_sync", 3);
    pulse_sample("irq_masked");
    tick("irq_masked2");
    bus.i_p_i = 1'b0;
    pulse_sample("irq_take");
    tick("irq_taken");
    pulse_lo("irq_lo");
    i_irq_n   = 1'b1;
    bus.i_p_i = 1'b1;
    pulse_hi("irq_hi");
    tick("irq_done", 3);

    // BRK with IRQ inactive.
    bus.i_brk = 1'b1;
    pulse_sample("brk_take");
    bus.i_brk = 1'b0;
    tick("brk_taken");
    pulse_lo("brk_lo");
    pulse_hi("brk_hi");
    tick("brk_done", 2);

    // IRQ hijacked by a late NMI.
    i_irq_n   = 1'b0;
    bus.i_p_i = 1'b0;
    tick("hj_sync", 3);
    pulse_sample("hj_take");
    i_irq_n   = 1'b1;
    bus.i_p_i = 1'b1;
    i_nmi_n   = 1'b0;
    tick("hj_wait", 5);
    pulse_lo("hj_lo");
    pulse_hi("hj_hi");
    tick("hj_done", 2);
    i_nmi_n = 1'b1;
    tick("hj_rel", 3);

    // Held-low NMI: one sequence only, re-fall gives another.
    i_nmi_n = 1'b0;
    tick("nmi_sync", 4);
    pulse_sample("nmi_take");
    pulse_lo("nmi_lo");
    pulse_hi("nmi_hi");
    tick("nmi_gap", 2);
    pulse_sample("nmi_held");
    tick("nmi_held2", 2);
    i_nmi_n = 1'b1;
    tick("nmi_rel", 3);
    i_nmi_n = 1'b0;
    tick("nmi_refall", 4);
    pulse_sample("nmi_take2");
    tick("nmi_taken2");

    // Asynchronous reset in the middle of an NMI sequence.
    #2 i_reset_n = 1'b0;
    m_reset();
    #1;
    check("async.vec_sel", bus.o_vec_sel, e_sel());
    check("async.nmi_pend", {1'b0, o_nmi_pending}, {1'b0, m_pend});
    check("async.set_i", {1'b0, bus.o_set_i}, {1'b0, m_seti});
    tick("async_hold", 2);
    i_nmi_n = 1'b1;
    #2 i_reset_n = 1'b1;
    tick("async_rel", 2);
    pulse_hi("async_hi");
    tick("async_done", 2);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.i_sample = ($urandom_range(0, 3) == 0);
      bus.i_brk    = $urandom_range(0, 1);
      bus.i_vec_lo = ($urandom_range(0, 5) == 0);
      bus.i_vec_hi = ($urandom_range(0, 7) == 0);
      bus.i_p_i    = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0)
        i_irq_n = ~i_irq_n;
      if ($urandom_range(0, 9) == 0)
        i_nmi_n = ~i_nmi_n;
      if (i_reset_n == 1'b0)
        i_reset_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) begin
        i_reset_n = 1'b0;
        m_reset();
      end
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/interrupt_control.md
INTERRUPT_CONTROL -- requirements
Module: interrupt_control

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flip-flop stages synchronising i_nmi_n and i_irq_n (legal 1..4).
REQ-002 SHALL have port i_clk  input  1  CPU clock; all state updates on falling edge, matching the processor status register.
REQ-003 SHALL have port i_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_nmi_n  input  1  NMI pin, active-low, edge-sensitive.
REQ-005 SHALL have port i_irq_n  input  1  IRQ pin, active-low, level-sensitive.
REQ-006 SHALL have port i_p_i  input  1  current I flag from processor status register (1 = IRQ masked).
REQ-007 SHALL have port i_sample  input  1  sequencer pulse on final cycle of each instruction; interrupt decision point.
REQ-008 SHALL have port i_brk  input  1  decoded opcode is BRK (0x00), valid when i_sample=1.
REQ-009 SHALL have port i_vec_lo  input  1  sequencer pulse when vector low byte is fetched.
REQ-010 SHALL have port i_vec_hi  input  1  sequencer pulse when vector high byte is fetched; ends the interrupt sequence.
REQ-011 SHALL have port o_vec_sel  output  2  vector select: 0 none, 1 IRQ/BRK (FFFE), 2 NMI (FFFA), 3 RESET (FFFC).
REQ-012 SHALL have port o_force_brk  output  1  1 = sequencer forces 0x00 into IR (hardware interrupt, not BRK).
REQ-013 SHALL have port o_b_push  output  1  value of B bit pushed with P (1 = BRK, 0 = NMI/IRQ).
REQ-014 SHALL have port o_set_i  output  1  one-cycle pulse driving the status register I-set control.
REQ-015 SHALL have port o_nmi_pending  output  1  NMI edge latched, not yet serviced.

Function
REQ-016 SHALL implement states S_RESET, S_IDLE, S_TAKEN.
REQ-017 SHALL pass i_nmi_n and i_irq_n through SYNC_STAGES falling-edge flops (reset value 1) before any use.
REQ-018 SHALL set nmi_latch on a synchronised 1->0 transition of NMI; held-low NMI SHALL NOT retrigger; new edge requires release to 1 first.
REQ-019 SHALL define irq_req = (synchronised IRQ == 0) AND (i_p_i == 0), evaluated only at i_sample.
REQ-020 In S_IDLE with i_sample=1, SHALL select by priority NMI (nmi_latch) > IRQ (irq_req) > BRK (i_brk), enter S_TAKEN next edge; none -> stay S_IDLE.
REQ-021 In S_TAKEN, o_vec_sel SHALL be 2 (NMI) or 1 (IRQ/BRK); o_force_brk=1 for NMI/IRQ, 0 for BRK; o_b_push=1 only for BRK.
REQ-022 NMI hijack: in S_TAKEN with o_vec_sel=1, if nmi_latch is set before i_vec_lo, o_vec_sel SHALL switch to 2 from the next edge; o_b_push and o_force_brk SHALL keep their values.
REQ-023 On i_vec_lo, the vector selection SHALL freeze for the rest of the sequence.
REQ-024 On i_vec_hi in S_TAKEN or S_RESET, o_set_i SHALL pulse 1 for exactly one cycle and state SHALL return to S_IDLE.
REQ-025 nmi_latch SHALL clear on i_vec_hi when serviced vector was NMI; an NMI edge in that same cycle SHALL set it (set wins).
REQ-026 In S_IDLE, o_vec_sel=0, o_force_brk=0, o_b_push=0.
REQ-027 i_sample outside S_IDLE, and i_vec_lo/i_vec_hi in S_IDLE, SHALL be ignored.
REQ-028 o_nmi_pending SHALL equal nmi_latch.

Reset
REQ-029 Asserting i_reset_n=0 SHALL immediately (no clock) force S_RESET, nmi_latch=0, synchronisers=1, o_set_i=0, including mid-sequence.
REQ-030 In S_RESET: o_vec_sel=3, o_force_brk=1, o_b_push=0; NMI edges SHALL latch but not alter vector; exit only via i_vec_hi (REQ-024).

Verification
REQ-031 Reset release, pulse i_vec_hi -> o_vec_sel 3 until pulse, o_set_i=1 one cycle, then o_vec_sel=0.
REQ-032 i_irq_n=0, i_p_i=1, i_sample -> stays S_IDLE; i_p_i=0, i_sample -> o_vec_sel=1, o_force_brk=1, o_b_push=0.
REQ-033 i_brk=1, i_sample, IRQ inactive -> o_vec_sel=1, o_b_push=1, o_force_brk=0; i_vec_hi -> o_set_i pulse.
REQ-034 IRQ taken, NMI falling edge before i_vec_lo -> o_vec_sel 1->2; after i_vec_hi, o_nmi_pending=0.
REQ-035 i_nmi_n held low across two i_sample points -> exactly one NMI sequence; release and re-fall -> second sequence.
REQ-036 i_reset_n=0 while o_vec_sel=2 -> asynchronously o_vec_sel=3, o_nmi_pending=0.
